// File: rtl/row_requantise.sv
// row_requantise
// Serially converts a packed row of D signed 2W-bit accumulators into a packed
// row of D signed W-bit activations. Each element is rounded (half up) while
// SHIFT fractional bits are dropped. An optional ReLU or leaky ReLU is then
// applied, and the result is saturated to W bits. A single arithmetic lane is
// shared across the row, so one element completes per clock.

module row_requantise #(
    parameter int W          = 16,
    parameter int D          = 8,
    parameter int SHIFT      = 8,
    parameter int RELU       = 1,
    parameter int LEAK_SHIFT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*D*W-1:0]   packed_in,
    input  logic               in_v,
    output logic [D*W-1:0]     packed_out,
    output logic               out_v,
    output logic               busy,
    output logic               overrun
);

    // Accumulator width, extended working width, and row index width
    localparam int AW    = 2 * W;
    localparam int EW    = 2 * W + 1;
    localparam int IDX_W = (D > 1) ? $clog2(D) : 1;

    // Rounding constant 2^(SHIFT-1); collapses to zero when SHIFT is zero,
    // which turns the rounding add into a no-op.
    localparam logic signed [EW-1:0] ROUND_C = EW'((EW'(1) << SHIFT) >> 1);

    // Saturation bounds of a signed W-bit result, held at the working width
    localparam logic signed [EW-1:0] SAT_MAX = (EW'(1) << (W - 1)) - EW'(1);
    localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(D - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Round, rectify and saturate one accumulator into a W-bit activation
    function automatic logic [W-1:0] requant(input logic [AW-1:0] acc);
        logic signed [EW-1:0] a;
        logic signed [EW-1:0] t;
        // The extra bit keeps the rounding add from overflowing at the
        // positive end of the accumulator range.
        a = EW'($signed(acc));
        t = (a + ROUND_C) >>> SHIFT;
        if ((RELU != 0) && t[EW-1]) begin
            if (LEAK_SHIFT == 0) begin
                t = '0;
            end else begin
                // Arithmetic shift floors toward minus infinity
                t = t >>> LEAK_SHIFT;
            end
        end else begin
            t = t;
        end
        if (t > SAT_MAX) begin
            t = SAT_MAX;
        end else if (t < SAT_MIN) begin
            t = SAT_MIN;
        end else begin
            t = t;
        end
        return t[W-1:0];
    endfunction

    state_t              state_q;
    logic [IDX_W-1:0]    index_q;
    logic [2*D*W-1:0]    hold_q;
    logic [D*W-1:0]      packed_out_q;
    logic                out_v_q;
    logic                busy_q;
    logic                overrun_q;
    logic                in_v_q;

    logic                trigger_s;
    logic [AW-1:0]       elem_s;
    logic [W-1:0]        result_s;
    logic [D*W-1:0]      packed_out_d;

    // A new row is offered on the rising edge of the level valid
    assign trigger_s = in_v & ~in_v_q;

    // The captured row shifts left each RUN cycle, so the element being
    // processed always sits in the top slot of the holding register.
    assign elem_s   = hold_q[2*D*W-1 -: AW];
    assign result_s = requant(elem_s);

    // Merge the lane result into the output slice selected by the row index
    always_comb begin
        packed_out_d = packed_out_q;
        for (int i = 0; i < D; i++) begin
            if (index_q == IDX_W'(i)) begin
                packed_out_d[(D-1-i)*W +: W] = result_s;
            end else begin
                packed_out_d[(D-1-i)*W +: W] = packed_out_q[(D-1-i)*W +: W];
            end
        end
    end

    // Control FSM together with the holding register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            hold_q       <= '0;
            packed_out_q <= '0;
            out_v_q      <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            in_v_q       <= 1'b0;
        end else begin
            in_v_q <= in_v;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (trigger_s) begin
                        hold_q  <= packed_in;
                        out_v_q <= 1'b0;
                        busy_q  <= 1'b1;
                        index_q <= '0;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_RUN: begin
                    packed_out_q <= packed_out_d;
                    hold_q       <= hold_q << AW;
                    // A new row during RUN, including the completing cycle,
                    // is dropped and flagged; the captured row finishes as is.
                    if (trigger_s) begin
                        overrun_q <= 1'b1;
                    end else begin
                        overrun_q <= overrun_q;
                    end
                    if (index_q == LAST_IDX) begin
                        index_q <= '0;
                        out_v_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        index_q <= index_q + IDX_W'(1);
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    index_q <= '0;
                    out_v_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign packed_out = packed_out_q;
    assign out_v      = out_v_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_row_requantise.sv
// Bench for row_requantise: three instances (ReLU, plain saturation, leaky
// ReLU) share one stimulus stream. A transaction-level reference model
// predicts control outputs and row results, and hand-computed literal rows
// pin that model.

module tb_row_requantise;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int IW = 2 * D * W;
    localparam int OW = D * W;

    // Rounding row and its result under ReLU
    localparam logic [IW-1:0] ROW1 = {32'h00000100, 32'h00000180, 32'h0000017F,
                                      32'hFFFFFF00, 128'h0};
    localparam logic [OW-1:0] ROW1_A = {16'h0001, 16'h0002, 16'h0001, 16'h0000, 64'h0};
    // Saturation / leaky row and its results in each configuration
    localparam logic [IW-1:0] ROW2 = {32'h7FFFFFFF, 32'h80000000, 32'hFFFFFE80,
                                      32'hFFFFF000, 32'h00000300, 96'h0};
    localparam logic [OW-1:0] ROW2_A = {16'h7FFF, 16'h0000, 16'h0000, 16'h0000,
                                        16'h0003, 48'h0};
    localparam logic [OW-1:0] ROW2_S = {16'h7FFF, 16'h8000, 16'hFFFF, 16'hFFF0,
                                        16'h0003, 48'h0};
    localparam logic [OW-1:0] ROW2_L = {16'h7FFF, 16'h8000, 16'hFFFF, 16'hFFFE,
                                        16'h0003, 48'h0};

    logic          clk = 1'b0;
    logic          rst;
    logic          in_v;
    logic [IW-1:0] packed_in;
    logic [OW-1:0] out_a, out_s, out_l;
    logic          outv_a, outv_s, outv_l;
    logic          busy_a, busy_s, busy_l;
    logic          ovr_a, ovr_s, ovr_l;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    row_requantise #(.W(W), .D(D), .SHIFT(8), .RELU(1), .LEAK_SHIFT(0)) dut_a (
        .clk(clk), .rst(rst), .packed_in(packed_in), .in_v(in_v),
        .packed_out(out_a), .out_v(outv_a), .busy(busy_a), .overrun(ovr_a));

    row_requantise #(.W(W), .D(D), .SHIFT(8), .RELU(0), .LEAK_SHIFT(0)) dut_s (
        .clk(clk), .rst(rst), .packed_in(packed_in), .in_v(in_v),
        .packed_out(out_s), .out_v(outv_s), .busy(busy_s), .overrun(ovr_s));

    row_requantise #(.W(W), .D(D), .SHIFT(8), .RELU(1), .LEAK_SHIFT(3)) dut_l (
        .clk(clk), .rst(rst), .packed_in(packed_in), .in_v(in_v),
        .packed_out(out_l), .out_v(outv_l), .busy(busy_l), .overrun(ovr_l));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference arithmetic on plain 64-bit integers (SHIFT fixed at 8 here)
    function automatic logic [W-1:0] ref_elem(input logic [31:0] a, input int relu, input int leak);
        longint t;
        logic [63:0] u;
        t = longint'($signed(a));
        t = (t + 64'sd128) >>> 8;
        if (relu != 0 && t < 64'sd0) begin
            if (leak == 0) t = 64'sd0;
            else t = t >>> leak;
        end
        if (t > 64'sd32767) t = 64'sd32767;
        else if (t < -64'sd32768) t = -64'sd32768;
        u = t;
        return u[W-1:0];
    endfunction

    function automatic logic [OW-1:0] ref_row(input logic [IW-1:0] row, input int relu, input int leak);
        logic [OW-1:0] r;
        r = '0;
        for (int i = 0; i < D; i++)
            r[(D-1-i)*W +: W] = ref_elem(row[(D-1-i)*32 +: 32], relu, leak);
        return r;
    endfunction

    // Transaction model: a rising valid outside a busy window captures the
    // row and opens a D-cycle busy window; the row is visible when it ends.
    logic          m_prev;
    int            m_left;
    logic          m_outv, m_ovr, m_zero;
    logic [IW-1:0] m_row;

    always @(posedge clk) begin
        if (rst) begin
            m_prev <= 1'b0;
            m_left <= 0;
            m_outv <= 1'b0;
            m_ovr  <= 1'b0;
            m_zero <= 1'b1;
        end else begin
            m_prev <= in_v;
            if (m_left > 0) begin
                if (in_v && !m_prev) m_ovr <= 1'b1;
                m_left <= m_left - 1;
                if (m_left == 1) m_outv <= 1'b1;
            end else if (in_v && !m_prev) begin
                m_row  <= packed_in;
                m_left <= D;
                m_outv <= 1'b0;
                m_zero <= 1'b0;
            end
        end
    end

    // Compare every instance against the model on each falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_a", busy_a, m_left != 0);
            check("busy_s", busy_s, m_left != 0);
            check("busy_l", busy_l, m_left != 0);
            check("outv_a", outv_a, m_outv);
            check("outv_s", outv_s, m_outv);
            check("outv_l", outv_l, m_outv);
            check("ovr_a", ovr_a, m_ovr);
            check("ovr_l", ovr_l, m_ovr);
            if (m_outv) begin
                check("row_a", out_a, ref_row(m_row, 1, 0));
                check("row_s", out_s, ref_row(m_row, 0, 0));
                check("row_l", out_l, ref_row(m_row, 1, 3));
            end
            if (m_zero) begin
                check("zero_a", out_a, '0);
                check("zero_l", out_l, '0);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [IW-1:0] rnd_row;
        rst = 1'b1;
        in_v = 1'b0;
        packed_in = '0;
        @(negedge clk);
        chk_en = 1'b1;
        cyc(2);
        check("lit_reset_outv", outv_a, 1'b0);
        check("lit_reset_busy", busy_a, 1'b0);
        check("lit_reset_out", out_a, '0);
        rst = 1'b0;
        cyc(2);

        // Rounding row with exact latency pinned
        packed_in = ROW1;
        in_v = 1'b1;
        for (int j = 0; j < D; j++) begin
            @(negedge clk);
            check("lit_busy_window", busy_a, 1'b1);
            check("lit_outv_low", outv_a, 1'b0);
        end
        @(negedge clk);
        check("lit_busy_end", busy_a, 1'b0);
        check("lit_outv_high", outv_a, 1'b1);
        check("lit_round_row", out_a, ROW1_A);
        cyc(4);
        check("lit_no_recapture", {outv_a, busy_a}, 2'b10);

        // Saturation / leaky row after valid drops and rises again
        in_v = 1'b0;
        cyc(2);
        packed_in = ROW2;
        in_v = 1'b1;
        @(negedge clk);
        check("lit_outv_cleared", outv_a, 1'b0);
        cyc(D);
        check("lit_row2_a", out_a, ROW2_A);
        check("lit_row2_sat", out_s, ROW2_S);
        check("lit_row2_leaky", out_l, ROW2_L);

        // Overrun: second rising valid while busy is dropped
        in_v = 1'b0;
        cyc(1);
        packed_in = ROW1;
        in_v = 1'b1;
        cyc(1);
        in_v = 1'b0;
        cyc(1);
        packed_in = ROW2;
        in_v = 1'b1;
        cyc(1);
        check("lit_overrun_set", ovr_a, 1'b1);
        cyc(D);
        check("lit_overrun_row", out_a, ROW1_A);
        check("lit_overrun_sticky", ovr_a, 1'b1);

        // Reset in the middle of a row with valid held high
        in_v = 1'b0;
        cyc(1);
        packed_in = ROW2;
        in_v = 1'b1;
        cyc(3);
        rst = 1'b1;
        cyc(1);
        check("lit_rst_outs", {outv_a, busy_a, ovr_a}, 3'b000);
        check("lit_rst_row", out_s, '0);
        rst = 1'b0;
        cyc(1);
        check("lit_post_rst_busy", busy_s, 1'b1);
        cyc(D);
        check("lit_post_rst_row", out_s, ROW2_S);
        check("lit_post_rst_ovr", ovr_s, 1'b0);

        // Rising valid on the completing edge counts as an overrun
        in_v = 1'b0;
        cyc(1);
        packed_in = ROW1;
        in_v = 1'b1;
        cyc(1);
        in_v = 1'b0;
        cyc(D - 1);
        check("lit_pre_coincide_ovr", ovr_a, 1'b0);
        in_v = 1'b1;
        cyc(1);
        check("lit_coincide_ovr", ovr_a, 1'b1);
        check("lit_coincide_row", out_a, ROW1_A);
        cyc(3);
        check("lit_coincide_hold", {outv_a, busy_a}, 2'b10);

        // Random row, checked by the model only
        in_v = 1'b0;
        cyc(1);
        for (int i = 0; i < D; i++)
            rnd_row[(D-1-i)*32 +: 32] = (i % 2 == 0) ? $urandom() : ($urandom() >> 12);
        packed_in = rnd_row;
        in_v = 1'b1;
        cyc(D + 3);
        in_v = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
